// File: rtl/servant_irq_pkg.sv
// Shared constants, register-select decode and claim priority encoder for servant_irq_ctrl.
// No clocked logic; pure declarations and combinational helpers.
// Not applicable: no flow control at package level.
package servant_irq_pkg;

    localparam int MAX_CHANNELS = 32;

    localparam logic [7:0] OFF_PENDING = 8'h00;
    localparam logic [7:0] OFF_ENABLE  = 8'h04;
    localparam logic [7:0] OFF_MODE    = 8'h08;
    localparam logic [7:0] OFF_CLAIM   = 8'h0C;
    localparam logic [7:0] OFF_CNT     = 8'h10;

    typedef enum logic [2:0] {
        REG_PENDING,
        REG_ENABLE,
        REG_MODE,
        REG_CLAIM,
        REG_CNT,
        REG_NONE
    } reg_sel_e;

    // Word address carries byte-address bits [4:2].
    function automatic reg_sel_e decode_adr(input logic [2:0] adr);
        logic [7:0] off;
        off = {3'b000, adr, 2'b00};
        case (off)
            OFF_PENDING: decode_adr = REG_PENDING;
            OFF_ENABLE:  decode_adr = REG_ENABLE;
            OFF_MODE:    decode_adr = REG_MODE;
            OFF_CLAIM:   decode_adr = REG_CLAIM;
            OFF_CNT:     decode_adr = REG_CNT;
            default:     decode_adr = REG_NONE;
        endcase
    endfunction

    // Returns 1 + index of the lowest set bit, 0 when the vector is empty.
    function automatic logic [5:0] lowest_set(input logic [MAX_CHANNELS-1:0] v);
        lowest_set = '0;
        for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 6'(i + 1);
        end
    endfunction

endpackage

// File: rtl/servant_irq_sync.sv
// One interrupt line: multi-flop synchroniser followed by a rising-edge detector.
// Latency: SYNC_STAGES cycles to sync_lvl; rise is combinational on the synchronised level.
// No backpressure: free-running every cycle.
module servant_irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_lvl,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sr_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            prev_q <= 1'b0;
        end else begin
            sr_q   <= {sr_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sr_q[SYNC_STAGES-1];
        end
    end

    assign sync_lvl = sr_q[SYNC_STAGES-1];
    assign rise     = sr_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/servant_irq_ctrl.sv
// Wishbone-attached interrupt controller: per-channel level/edge pending, enable, claim.
// Latency: bus ack one cycle after stb; o_irq registered one cycle after pending&enable.
// No backpressure: every strobe is acked next cycle. SERVANT_IRQ_CLAIM_COUNT_EN adds CNT at 0x10.
module servant_irq_ctrl
    import servant_irq_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                wb_clk,
    input  logic                wb_rst_n,
    input  logic [CHANNELS-1:0] i_ext_irq,
    input  logic [2:0]          i_wb_adr,
    input  logic [31:0]         i_wb_dat,
    input  logic                i_wb_we,
    input  logic                i_wb_stb,
    output logic [31:0]         o_wb_rdt,
    output logic                o_wb_ack,
    output logic                o_irq
);

    logic [CHANNELS-1:0]     sync_lvl;
    logic [CHANNELS-1:0]     rise;
    logic [CHANNELS-1:0]     enable_q;
    logic [CHANNELS-1:0]     mode_q;
    logic [CHANNELS-1:0]     edge_pend_q;
    logic [CHANNELS-1:0]     pending;
    logic [CHANNELS-1:0]     enable_d;
    logic [CHANNELS-1:0]     mode_d;
    logic [CHANNELS-1:0]     edge_pend_d;
    logic [CHANNELS-1:0]     w1c_clr;
    logic [CHANNELS-1:0]     claim_clr;
    logic [MAX_CHANNELS-1:0] masked_ext;
    logic [5:0]              claim_id;
    logic                    claim_rd;
    logic                    acc;
    logic                    wr_acc;
    logic                    rd_acc;
    logic [31:0]             rd_data;
    reg_sel_e                sel;
    logic                    unused_ok;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_sync
        servant_irq_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk      (wb_clk),
            .rst_n    (wb_rst_n),
            .async_in (i_ext_irq[gi]),
            .sync_lvl (sync_lvl[gi]),
            .rise     (rise[gi])
        );
    end

    // edge_pend_q is held at zero for level channels, so the OR is a clean per-bit mux.
    assign pending = edge_pend_q | (sync_lvl & ~mode_q);

    // Side effects happen only on the edge that raises ack.
    assign acc    = i_wb_stb & ~o_wb_ack;
    assign wr_acc = acc & i_wb_we;
    assign rd_acc = acc & ~i_wb_we;
    assign sel    = decode_adr(i_wb_adr);

    assign unused_ok = &{1'b0, i_wb_dat};

`ifdef SERVANT_IRQ_CLAIM_COUNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cnt_q <= '0;
        end else if (wr_acc && (sel == REG_CNT)) begin
            cnt_q <= '0;
        end else if (claim_rd && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end
`endif

    always_comb begin
        masked_ext                = '0;
        masked_ext[CHANNELS-1:0]  = pending & enable_q;
        claim_id                  = lowest_set(masked_ext);
        claim_rd                  = rd_acc && (sel == REG_CLAIM) && (claim_id != 6'd0);

        claim_clr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            claim_clr[i] = claim_rd && (claim_id == 6'(i + 1)) && mode_q[i];
        end

        w1c_clr  = (wr_acc && (sel == REG_PENDING)) ? i_wb_dat[CHANNELS-1:0] : '0;
        enable_d = (wr_acc && (sel == REG_ENABLE))  ? i_wb_dat[CHANNELS-1:0] : enable_q;
        mode_d   = (wr_acc && (sel == REG_MODE))    ? i_wb_dat[CHANNELS-1:0] : mode_q;

        // A fresh edge beats a same-cycle clear; a mode change in either direction drops latched state.
        edge_pend_d = mode_d & mode_q & (rise | (edge_pend_q & ~(w1c_clr | claim_clr)));
        edge_pend_d = edge_pend_d | (mode_d & ~mode_q & rise);

        rd_data = '0;
        case (sel)
            REG_PENDING: rd_data[CHANNELS-1:0] = pending;
            REG_ENABLE:  rd_data[CHANNELS-1:0] = enable_q;
            REG_MODE:    rd_data[CHANNELS-1:0] = mode_q;
            REG_CLAIM:   rd_data[5:0]          = claim_id;
`ifdef SERVANT_IRQ_CLAIM_COUNT_EN
            REG_CNT:     rd_data               = cnt_q;
`endif
            default:     rd_data               = '0;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            enable_q    <= '0;
            mode_q      <= '0;
            edge_pend_q <= '0;
            o_wb_ack    <= 1'b0;
            o_wb_rdt    <= '0;
            o_irq       <= 1'b0;
        end else begin
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            edge_pend_q <= edge_pend_d;
            o_wb_ack    <= acc;
            o_irq       <= |(pending & enable_q);
            if (acc) begin
                o_wb_rdt <= i_wb_we ? 32'd0 : rd_data;
            end
        end
    end

endmodule

// File: tb/tb_servant_irq_ctrl.sv
// Self-checking bench for servant_irq_ctrl: directed scenarios plus random traffic
// compared against a behavioural model of the register rules.
module tb_servant_irq_ctrl;

    localparam int CH = 4;
    localparam int S  = 2;
    localparam logic [31:0] MASK = (32'd1 << CH) - 32'd1;

    logic          wb_clk = 1'b0;
    logic          wb_rst_n;
    logic [CH-1:0] i_ext_irq;
    logic [2:0]    i_wb_adr;
    logic [31:0]   i_wb_dat;
    logic          i_wb_we;
    logic          i_wb_stb;
    logic [31:0]   o_wb_rdt;
    logic          o_wb_ack;
    logic          o_irq;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    servant_irq_ctrl #(
        .CHANNELS    (CH),
        .SYNC_STAGES (S)
    ) dut (
        .wb_clk    (wb_clk),
        .wb_rst_n  (wb_rst_n),
        .i_ext_irq (i_ext_irq),
        .i_wb_adr  (i_wb_adr),
        .i_wb_dat  (i_wb_dat),
        .i_wb_we   (i_wb_we),
        .i_wb_stb  (i_wb_stb),
        .o_wb_rdt  (o_wb_rdt),
        .o_wb_ack  (o_wb_ack),
        .o_irq     (o_irq)
    );

    always #5 wb_clk = ~wb_clk;

    // Reference model: input seen S edges late, pending from level/edge rules.
    logic [31:0] samp [0:S];
    logic [31:0] m_en, m_mode, m_edge, m_rdt, m_cnt;
    logic        m_irq, m_ack;

    always @(posedge wb_clk or negedge wb_rst_n) begin
        logic [31:0] sync_v, rise_v, pend_v, act_v, clr_v, en_n, mode_n, rdt_n, dat_m;
        int id;
        if (!wb_rst_n) begin
            m_en = 0; m_mode = 0; m_edge = 0; m_rdt = 0; m_cnt = 0;
            m_irq = 0; m_ack = 0;
            for (int i = 0; i <= S; i++) samp[i] = 0;
        end else begin
            sync_v = samp[S-1];
            rise_v = sync_v & ~samp[S];
            pend_v = m_edge | (sync_v & ~m_mode);
            act_v  = pend_v & m_en;
            en_n = m_en; mode_n = m_mode; rdt_n = m_rdt; clr_v = 0;
            dat_m = i_wb_dat & MASK;
            if (i_wb_stb && !m_ack) begin
                rdt_n = 0;
                if (i_wb_we) begin
                    case (i_wb_adr)
                        3'd0: clr_v = dat_m & m_mode;
                        3'd1: en_n = dat_m;
                        3'd2: mode_n = dat_m;
`ifdef SERVANT_IRQ_CLAIM_COUNT_EN
                        3'd4: m_cnt = 0;
`endif
                        default: ;
                    endcase
                end else begin
                    case (i_wb_adr)
                        3'd0: rdt_n = pend_v;
                        3'd1: rdt_n = m_en;
                        3'd2: rdt_n = m_mode;
                        3'd3: begin
                            id = 0;
                            for (int i = CH - 1; i >= 0; i--) if (act_v[i]) id = i + 1;
                            rdt_n = 32'(id);
                            if (id != 0) begin
                                if (m_mode[id-1]) clr_v[id-1] = 1'b1;
                                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                            end
                        end
`ifdef SERVANT_IRQ_CLAIM_COUNT_EN
                        3'd4: rdt_n = m_cnt;
`endif
                        default: ;
                    endcase
                end
            end
            m_irq  = (act_v != 0);
            m_ack  = i_wb_stb && !m_ack;
            m_edge = mode_n & (rise_v | (m_edge & ~clr_v & m_mode));
            m_en = en_n; m_mode = mode_n; m_rdt = rdt_n;
            for (int i = S; i > 0; i--) samp[i] = samp[i-1];
            samp[0] = 32'(i_ext_irq);
        end
    end

    always @(negedge wb_clk) begin
        if (wb_rst_n && mon_en) begin
            checks++;
            if (o_irq !== m_irq) begin
                errors++;
                $display("FAIL irq_monitor: got %b expected %b at %0t", o_irq, m_irq, $time);
            end
            checks++;
            if (o_wb_ack !== m_ack) begin
                errors++;
                $display("FAIL ack_monitor: got %b expected %b at %0t", o_wb_ack, m_ack, $time);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    // Both bus tasks start and end on a falling edge.
    task automatic bus_read(input logic [2:0] adr, output logic [31:0] d, output logic [31:0] e);
        i_wb_adr = adr; i_wb_we = 1'b0; i_wb_stb = 1'b1;
        @(negedge wb_clk);
        d = o_wb_rdt;
        e = m_rdt;
        i_wb_stb = 1'b0;
        @(negedge wb_clk);
    endtask

    task automatic bus_write(input logic [2:0] adr, input logic [31:0] dat);
        i_wb_adr = adr; i_wb_dat = dat; i_wb_we = 1'b1; i_wb_stb = 1'b1;
        @(negedge wb_clk);
        i_wb_stb = 1'b0; i_wb_we = 1'b0;
        @(negedge wb_clk);
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        checks++;
        if (o_irq !== 1'b0 || o_wb_ack !== 1'b0 || o_wb_rdt !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got irq=%b ack=%b rdt=%h required 0/0/0", o_irq, o_wb_ack, o_wb_rdt);
        end
        wb_rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge wb_clk);
        for (int a = 0; a < 4; a++) begin
            bus_read(3'(a), d, e);
            checks++;
            if (d !== 32'd0 || d !== e) begin
                errors++;
                $display("FAIL reset_read adr=%0d: got %h required 0 (model %h)", a, d, e);
            end
        end
    endtask

    task automatic test_level();
        logic [31:0] d, e;
        bus_write(3'd2, 32'h0);
        bus_write(3'd1, 32'hF);
        i_ext_irq = 4'h4;
        repeat (S) @(negedge wb_clk);
        checks++;
        if (o_irq !== 1'b0) begin
            errors++;
            $display("FAIL level_irq_early: got %b required 0", o_irq);
        end
        @(negedge wb_clk);
        checks++;
        if (o_irq !== 1'b1) begin
            errors++;
            $display("FAIL level_irq_latency: got %b required 1", o_irq);
        end
        bus_read(3'd3, d, e);
        checks++;
        if (d !== 32'd3 || d !== e) begin
            errors++;
            $display("FAIL level_claim: got %h required 3 (model %h)", d, e);
        end
        i_ext_irq = 4'h0;
        repeat (S + 1) @(negedge wb_clk);
        bus_read(3'd0, d, e);
        checks++;
        if (d !== 32'd0 || d !== e) begin
            errors++;
            $display("FAIL level_pending_clear: got %h required 0 (model %h)", d, e);
        end
        checks++;
        if (o_irq !== 1'b0) begin
            errors++;
            $display("FAIL level_irq_low: got %b required 0", o_irq);
        end
    endtask

    task automatic test_edge();
        logic [31:0] d, e;
        bus_write(3'd2, 32'h1);
        i_ext_irq = 4'h1;
        repeat (3) @(negedge wb_clk);
        i_ext_irq = 4'h0;
        repeat (S + 6) @(negedge wb_clk);
        bus_read(3'd0, d, e);
        checks++;
        if (d !== 32'd1 || d !== e) begin
            errors++;
            $display("FAIL edge_pending_held: got %h required 1 (model %h)", d, e);
        end
        checks++;
        if (o_irq !== 1'b1) begin
            errors++;
            $display("FAIL edge_irq_high: got %b required 1", o_irq);
        end
        bus_read(3'd3, d, e);
        checks++;
        if (d !== 32'd1 || d !== e) begin
            errors++;
            $display("FAIL edge_claim_first: got %h required 1 (model %h)", d, e);
        end
        bus_read(3'd3, d, e);
        checks++;
        if (d !== 32'd0 || d !== e) begin
            errors++;
            $display("FAIL edge_claim_second: got %h required 0 (model %h)", d, e);
        end
        checks++;
        if (o_irq !== 1'b0) begin
            errors++;
            $display("FAIL edge_irq_fall: got %b required 0", o_irq);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d, e;
        bus_write(3'd2, 32'h2);
        i_ext_irq = 4'h2;
        repeat (3) @(negedge wb_clk);
        i_ext_irq = 4'h0;
        repeat (S + 2) @(negedge wb_clk);
        // Rise reaches the pending logic exactly on the W1C access edge.
        i_ext_irq = 4'h2;
        repeat (S) @(negedge wb_clk);
        bus_write(3'd0, 32'h2);
        bus_read(3'd0, d, e);
        checks++;
        if (d !== 32'h2 || d !== e) begin
            errors++;
            $display("FAIL collision_set_wins: got %h required 2 (model %h)", d, e);
        end
        i_ext_irq = 4'h0;
        repeat (S + 2) @(negedge wb_clk);
        bus_write(3'd0, 32'h2);
        bus_read(3'd0, d, e);
        checks++;
        if (d !== 32'h0 || d !== e) begin
            errors++;
            $display("FAIL collision_w1c: got %h required 0 (model %h)", d, e);
        end
    endtask

    task automatic test_mask();
        logic [31:0] d, e;
        bus_write(3'd2, 32'h0);
        bus_write(3'd0, 32'hF);
        i_ext_irq = 4'h6;
        repeat (S + 1) @(negedge wb_clk);
        bus_write(3'd1, 32'h4);
        bus_read(3'd3, d, e);
        checks++;
        if (d !== 32'd3 || d !== e) begin
            errors++;
            $display("FAIL mask_claim: got %h required 3 (model %h)", d, e);
        end
        bus_write(3'd1, 32'h0);
        repeat (2) @(negedge wb_clk);
        checks++;
        if (o_irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_irq_low: got %b required 0", o_irq);
        end
        bus_read(3'd0, d, e);
        checks++;
        if (d !== 32'h6 || d !== e) begin
            errors++;
            $display("FAIL mask_pending: got %h required 6 (model %h)", d, e);
        end
        i_ext_irq = 4'h0;
        repeat (S + 2) @(negedge wb_clk);
    endtask

    task automatic test_mode_change();
        logic [31:0] d, e;
        bus_write(3'd1, 32'hF);
        bus_write(3'd2, 32'h1);
        i_ext_irq = 4'h1;
        repeat (2) @(negedge wb_clk);
        i_ext_irq = 4'h0;
        repeat (S + 2) @(negedge wb_clk);
        bus_write(3'd2, 32'h0);
        bus_read(3'd0, d, e);
        checks++;
        if (d !== 32'h0 || d !== e) begin
            errors++;
            $display("FAIL mode_edge_to_level: got %h required 0 (model %h)", d, e);
        end
        i_ext_irq = 4'h1;
        repeat (S + 2) @(negedge wb_clk);
        bus_read(3'd0, d, e);
        checks++;
        if (d !== 32'h1 || d !== e) begin
            errors++;
            $display("FAIL mode_level_high: got %h required 1 (model %h)", d, e);
        end
        bus_write(3'd2, 32'h1);
        bus_read(3'd0, d, e);
        checks++;
        if (d !== 32'h0 || d !== e) begin
            errors++;
            $display("FAIL mode_level_to_edge: got %h required 0 (model %h)", d, e);
        end
        i_ext_irq = 4'h0;
        repeat (S + 2) @(negedge wb_clk);
    endtask

    task automatic test_undecoded();
        logic [31:0] d, e;
        bus_write(3'd1, 32'hFFFF_FFFF);
        bus_write(3'd3, 32'h0);
        bus_write(3'd5, 32'h0);
        bus_write(3'd6, 32'h0);
        bus_write(3'd7, 32'h0);
        bus_read(3'd1, d, e);
        checks++;
        if (d !== 32'hF || d !== e) begin
            errors++;
            $display("FAIL undecoded_enable: got %h required F (model %h)", d, e);
        end
        for (int a = 5; a < 8; a++) begin
            bus_read(3'(a), d, e);
            checks++;
            if (d !== 32'h0 || d !== e) begin
                errors++;
                $display("FAIL undecoded_read adr=%0d: got %h required 0 (model %h)", a, d, e);
            end
        end
    endtask

    task automatic test_count();
        logic [31:0] d, e;
        bus_write(3'd2, 32'h0);
        bus_write(3'd1, 32'h1);
        i_ext_irq = 4'h1;
        repeat (S + 1) @(negedge wb_clk);
        bus_write(3'd4, 32'h0);
        for (int k = 0; k < 3; k++) begin
            bus_read(3'd3, d, e);
            checks++;
            if (d !== 32'd1 || d !== e) begin
                errors++;
                $display("FAIL count_claim %0d: got %h required 1 (model %h)", k, d, e);
            end
        end
        bus_write(3'd1, 32'h0);
        bus_read(3'd3, d, e);
        bus_read(3'd4, d, e);
`ifdef SERVANT_IRQ_CLAIM_COUNT_EN
        checks++;
        if (d !== 32'd3 || d !== e) begin
            errors++;
            $display("FAIL count_value: got %h required 3 (model %h)", d, e);
        end
        bus_write(3'd4, 32'h1234);
        bus_read(3'd4, d, e);
        checks++;
        if (d !== 32'd0 || d !== e) begin
            errors++;
            $display("FAIL count_clear: got %h required 0 (model %h)", d, e);
        end
`else
        checks++;
        if (d !== 32'd0 || d !== e) begin
            errors++;
            $display("FAIL count_absent: got %h required 0 (model %h)", d, e);
        end
`endif
        i_ext_irq = 4'h0;
        repeat (S + 2) @(negedge wb_clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, e;
        bus_write(3'd2, 32'h0);
        bus_write(3'd1, 32'hF);
        i_ext_irq = 4'h1;
        repeat (S + 2) @(negedge wb_clk);
        i_wb_adr = 3'd0; i_wb_we = 1'b0; i_wb_stb = 1'b1;
        @(posedge wb_clk);
        #1;
        checks++;
        if (o_wb_ack !== 1'b1 || o_irq !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: got ack=%b irq=%b required 1/1", o_wb_ack, o_irq);
        end
        mon_en = 1'b0;
        wb_rst_n = 1'b0;
        #1;
        checks++;
        if (o_wb_ack !== 1'b0 || o_irq !== 1'b0 || o_wb_rdt !== 32'd0) begin
            errors++;
            $display("FAIL midreset_clear: got ack=%b irq=%b rdt=%h required 0/0/0", o_wb_ack, o_irq, o_wb_rdt);
        end
        i_wb_stb = 1'b0;
        i_ext_irq = 4'h0;
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        mon_en = 1'b1;
        bus_read(3'd1, d, e);
        checks++;
        if (d !== 32'd0 || d !== e) begin
            errors++;
            $display("FAIL midreset_enable: got %h required 0 (model %h)", d, e);
        end
        bus_read(3'd0, d, e);
        checks++;
        if (d !== 32'd0 || d !== e) begin
            errors++;
            $display("FAIL midreset_pending: got %h required 0 (model %h)", d, e);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, e;
        logic [2:0]  a;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 3) == 0) i_ext_irq = CH'($urandom);
            case ($urandom_range(0, 5))
                0: @(negedge wb_clk);
                1, 2: begin
                    a = 3'($urandom_range(0, 7));
                    if ($urandom_range(0, 1) == 1) a = 3'd3;
                    bus_read(a, d, e);
                    checks++;
                    if (d !== e) begin
                        errors++;
                        $display("FAIL random_read adr=%0d iter=%0d: got %h required %h", a, n, d, e);
                    end
                end
                3: bus_write(3'($urandom_range(0, 5)), $urandom);
                default: bus_write(3'($urandom_range(1, 2)), $urandom);
            endcase
        end
    endtask

    initial begin
        wb_rst_n  = 1'b0;
        i_ext_irq = '0;
        i_wb_adr  = '0;
        i_wb_dat  = '0;
        i_wb_we   = 1'b0;
        i_wb_stb  = 1'b0;
        repeat (3) @(negedge wb_clk);
        test_reset();
        test_level();
        test_edge();
        test_collision();
        test_mask();
        test_mode_change();
        test_undecoded();
        test_count();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/servant_irq_ctrl.md
SERVANT_IRQ_CTRL -- requirements
Module: servant_irq_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of external interrupt inputs (legal 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth per input (legal 2..4).
REQ-003 SHALL have port wb_clk  input  1  system clock.
REQ-004 SHALL have port wb_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_ext_irq  input  CHANNELS  asynchronous interrupt request lines.
REQ-006 SHALL have port i_wb_adr  input  3  word address, byte address bits [4:2].
REQ-007 SHALL have port i_wb_dat  input  32  write data.
REQ-008 SHALL have port i_wb_we  input  1  write enable.
REQ-009 SHALL have port i_wb_stb  input  1  bus strobe.
REQ-010 SHALL have port o_wb_rdt  output  32  read data.
REQ-011 SHALL have port o_wb_ack  output  1  bus acknowledge.
REQ-012 SHALL have port o_irq  output  1  aggregated interrupt to the CPU external_irq input.

Function
REQ-013 SHALL synchronise each i_ext_irq bit through SYNC_STAGES flops before use.
REQ-014 SHALL hold registers PENDING (0x0), ENABLE (0x4, rw), MODE (0x8, rw; 1 = rising-edge, 0 = level) and CLAIM (0xC, read-only), each CHANNELS bits wide, zero-extended to 32 on read.
REQ-015 Level channel: PENDING bit SHALL equal the synchronised input each cycle; writes to that bit are ignored.
REQ-016 Edge channel: PENDING bit SHALL set one cycle after a synchronised 0->1 transition and hold until cleared.
REQ-017 Write to PENDING SHALL clear edge-channel bits written as 1 (W1C).
REQ-018 Edge detected in the same cycle as a W1C or claim of the same bit: set SHALL win.
REQ-019 Read of CLAIM SHALL return 1 + index of the lowest-numbered bit of PENDING & ENABLE, or 0 if none; for an edge channel the read SHALL clear that pending bit.
REQ-020 Writes to CLAIM and to undecoded addresses SHALL be ignored; reads of undecoded addresses SHALL return 0.
REQ-021 o_wb_ack SHALL rise one cycle after i_wb_stb and fall the next cycle (ack <= stb & !ack); register side effects SHALL occur only in the cycle ack is driven high.
REQ-022 o_wb_rdt SHALL be registered and valid in the ack cycle.
REQ-023 o_irq SHALL be registered: |(PENDING & ENABLE) from the previous cycle.
REQ-024 Changing MODE from edge to level SHALL discard the latched edge pending bit; level to edge SHALL start with PENDING clear.

Reset
REQ-025 Asserting wb_rst_n low SHALL immediately clear synchronisers, edge-history flops, PENDING, ENABLE, MODE, o_wb_rdt, o_wb_ack, o_irq and the claim counter.
REQ-026 Reset mid-transaction SHALL drop the pending ack; the first stb after reset release SHALL be served normally.

Configuration
REQ-027 Macro SERVANT_IRQ_CLAIM_COUNT_EN, when defined, SHALL add register CNT (0x10): 32-bit count of CLAIM reads returning non-zero, saturating at 0xFFFFFFFF, W1C-style clear by writing any value.
REQ-028 Without SERVANT_IRQ_CLAIM_COUNT_EN, address 0x10 SHALL behave as undecoded and no counter logic SHALL exist.

Structure
REQ-029 Package servant_irq_pkg SHALL hold register-offset constants, the register-select enum and the max-CHANNELS constant.
REQ-030 Sub-module servant_irq_sync SHALL implement one channel's synchroniser plus rising-edge detect, instantiated CHANNELS times.

Verification
REQ-031 Reset, then read 0x0/0x4/0x8/0xC -> all return 0; o_irq = 0.
REQ-032 CHANNELS=4, ENABLE=0xF, MODE=0x0, drive i_ext_irq=0x4 -> o_irq high SYNC_STAGES+1 cycles later; CLAIM reads 3; deassert input -> PENDING 0, o_irq low.
REQ-033 MODE=0x1, pulse i_ext_irq[0] for 3 cycles -> PENDING=0x1 held; CLAIM reads 1 then 0; o_irq falls.
REQ-034 Edge on ch1 coincident with W1C of 0x2 -> PENDING bit1 remains 1.
REQ-035 Pending 0x6 with ENABLE=0x4 -> CLAIM reads 3; ENABLE=0 -> o_irq low while PENDING still 0x6.
REQ-036 With SERVANT_IRQ_CLAIM_COUNT_EN, three non-zero claims -> CNT reads 3; write 0x10 -> CNT reads 0; without macro 0x10 reads 0.
